regfile_multiport: RTL and testbench
====================================

// Module: regfile_multiport
// PURPOSE
//  Parametrised multi-read-port register file for the next-generation core datapath.
//  - One synchronous write port; NUM_RD asynchronous (combinational) read ports.
//  - Optional hard-wired zero register.
//  - Built-in sequential clear engine zeroes every entry after reset and on request, flagged by busy.
// PARAMETERS
//  WIDTH     32  data width of each entry
//  DEPTH     32  number of entries; power of two, >=2
//  AW        5   address width, =$clog2(DEPTH)
//  NUM_RD    2   number of read ports, 1..4
//  ZERO_REG  1   1: entry 0 always reads 0 and ignores writes; 0: entry 0 is ordinary
// PORTS
//  clk      in   1             clock, all state on rising edge
//  rst      in   1             reset, asynchronous, active-low
//  clr_req  in   1             pulse: start full clear of the bank
//  busy     out  1             1 while the clear engine runs
//  we       in   1             write enable
//  waddr    in   AW            write address
//  wdata    in   WIDTH         write data
//  raddr    in   NUM_RD*AW     read addresses; port i = raddr[i*AW +: AW]
//  rdata    out  NUM_RD*WIDTH  read data; port i = rdata[i*WIDTH +: WIDTH]
// BEHAVIOUR
//  - Reset: clk single clock; rst asynchronous, active-low.
//  - rst low: state=CLEAR, clr_cnt=0, busy=1, all rdata=0; array contents not touched by reset itself.
//  - FSM IDLE/CLEAR:
//    - CLEAR: each edge writes 0 to bank[clr_cnt], clr_cnt++.
//    - Edge that writes clr_cnt==DEPTH-1 -> IDLE, busy=0 from the next cycle.
//    - Clear lasts exactly DEPTH cycles after rst release.
//  - IDLE + clr_req=1 at an edge -> CLEAR, clr_cnt=0, busy=1 next cycle.
//  - clr_req while in CLEAR is ignored; no restart, no extension.
//  - rst asserted mid-clear aborts and restarts the clear at entry 0 on release.
//  - Writes:
//    - Accepted at the rising edge when we=1 and busy=0.
//    - we=1 while busy=1 is silently dropped.
//    - ZERO_REG=1: writes to waddr==0 dropped.
//  - Same-edge clr_req and write in IDLE: the write commits, then the clear overwrites it in turn.
//  - Reads:
//    - Combinational, zero latency: rdata_i = bank[raddr_i].
//    - ZERO_REG=1 and raddr_i==0 -> 0.
//    - busy=1 -> every rdata_i forced to 0, so uncleared entries are never visible.
//  - Any number of read ports may address the same entry simultaneously; all return the same value.
//  - Address width exact, no wrap logic; DEPTH is a power of two so every address is valid.
// CONFIGURATION
//  REGFILE_BYPASS_EN defined:
//    - Write-through forwarding: when we=1, busy=0, waddr==raddr_i and the write is not dropped (ZERO_REG rule),
//      rdata_i = wdata in the same cycle, before the edge.
//    - Applied independently per read port.
//  REGFILE_BYPASS_EN undefined:
//    - rdata_i shows the stored (old) value until the write edge; new value visible the cycle after.
// TESTING (WIDTH=32, DEPTH=32, NUM_RD=2, ZERO_REG=1)
//  1. Release rst -> busy=1 for exactly 32 cycles, then 0; read all 32 entries -> 0 each.
//  2. busy=0; write 0xDEADBEEF to 5, 0x12345678 to 31; next cycle raddr={5,31}
//     -> rdata={0xDEADBEEF,0x12345678}; both ports on 5 -> both 0xDEADBEEF.
//  3. Write 0xFFFFFFFF to 0 -> read 0 returns 0; write during busy=1 to 7 -> entry 7 still 0 after clear.
//  4. Store 0xA5A5A5A5 at 9; clr_req pulse; clr_req again at clear cycle 10
//     -> busy exactly 32 cycles; entry 9 reads 0 afterwards.
//  5. Drop rst at clear cycle 15, release -> busy 32 further cycles from release; rdata=0 throughout.
//  6. Entry 3 = 0x1; same cycle we=1, waddr=3, wdata=0x2, raddr_0=3:
//     -> pre-edge rdata_0=0x2 with REGFILE_BYPASS_EN, 0x1 without; post-edge 0x2 in both builds.

Source files
------------

// File: rtl/regfile_multiport.sv
// Multi-read-port register file with a synchronous write port, combinational read ports,
// an optional hard-wired zero entry and a sequential clear engine that runs after reset
// and on request. While the engine runs, busy is high, writes are dropped and reads return 0.
// Optional feature macro: REGFILE_BYPASS_EN forwards the write data to any read port
// that addresses the entry being written in the same cycle.
module regfile_multiport #(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 32,
    parameter int unsigned AW       = $clog2(DEPTH),
    parameter int unsigned NUM_RD   = 2,
    parameter bit          ZERO_REG = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    clr_req,
    output logic                    busy,
    input  logic                    we,
    input  logic [AW-1:0]           waddr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [NUM_RD*AW-1:0]    raddr,
    output logic [NUM_RD*WIDTH-1:0] rdata
);

    typedef enum logic [0:0] {StIdle, StClear} state_e;

    state_e          state_q;
    logic            busy_q;
    logic [AW-1:0]   clr_cnt_q;
    logic [WIDTH-1:0] bank [DEPTH];
    logic            wr_en;

    // A write lands only when the clear engine is idle and it does not target the zero entry
    assign wr_en = we && !busy_q && !(ZERO_REG && (waddr == '0));
    assign busy  = busy_q;

    // Clear-engine FSM: reset parks it at entry 0 in CLEAR, so the bank is swept after release
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= StClear;
            busy_q    <= 1'b1;
            clr_cnt_q <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (clr_req) begin
                        state_q   <= StClear;
                        busy_q    <= 1'b1;
                        clr_cnt_q <= '0;
                    end
                end
                StClear: begin
                    // clr_req is ignored here: the sweep neither restarts nor extends
                    if (clr_cnt_q == AW'(DEPTH - 1)) begin
                        state_q   <= StIdle;
                        busy_q    <= 1'b0;
                        clr_cnt_q <= '0;
                    end else begin
                        clr_cnt_q <= clr_cnt_q + AW'(1);
                    end
                end
                default: begin
                    state_q <= StIdle;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array: the clear sweep owns the write port while busy, otherwise the user write
    always_ff @(posedge clk) begin
        if (busy_q) begin
            bank[clr_cnt_q] <= '0;
        end else if (wr_en) begin
            bank[waddr] <= wdata;
        end
    end

    // Combinational read ports with zero-entry masking and busy masking
    always_comb begin
        logic [AW-1:0]    ra;
        logic [WIDTH-1:0] rd;
        rdata = '0;
        ra    = '0;
        rd    = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            ra = raddr[i*AW +: AW];
            rd = bank[ra];
`ifdef REGFILE_BYPASS_EN
            if (wr_en && (waddr == ra)) begin
                rd = wdata;
            end
`endif
            if (ZERO_REG && (ra == '0)) begin
                rd = '0;
            end
            // Hide entries the sweep has not reached yet
            if (busy_q) begin
                rd = '0;
            end
            rdata[i*WIDTH +: WIDTH] = rd;
        end
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Directed self-checking bench for regfile_multiport (WIDTH=32, DEPTH=32, NUM_RD=2, ZERO_REG=1).
module tb_regfile_multiport;

    localparam int WIDTH  = 32;
    localparam int DEPTH  = 32;
    localparam int AW     = 5;
    localparam int NUM_RD = 2;

    logic                    clk;
    logic                    rst;
    logic                    clr_req;
    logic                    busy;
    logic                    we;
    logic [AW-1:0]           waddr;
    logic [WIDTH-1:0]        wdata;
    logic [NUM_RD*AW-1:0]    raddr;
    logic [NUM_RD*WIDTH-1:0] rdata;

    int n_vec;
    int n_err;

    regfile_multiport #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .AW      (AW),
        .NUM_RD  (NUM_RD),
        .ZERO_REG(1'b1)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .clr_req(clr_req),
        .busy   (busy),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr  (raddr),
        .rdata  (rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge, away from the active edge
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Write one entry through the user port (one rising edge)
    task automatic do_write(input logic [AW-1:0] a, input logic [WIDTH-1:0] d);
        we    = 1'b1;
        waddr = a;
        wdata = d;
        tick();
        we    = 1'b0;
    endtask

    // Count consecutive busy samples (one per cycle), also noting any nonzero read data
    task automatic measure_busy(output int cnt, output bit saw_data);
        cnt      = 0;
        saw_data = 1'b0;
        while (busy === 1'b1 && cnt < 100) begin
            if (rdata !== '0) saw_data = 1'b1;
            cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        int  cnt;
        bit  saw;
        rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL reset_busy: got %b want 1", busy);
        end
        tick();
        tick();
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL reset_rdata: got %h want 0", rdata);
        end
        rst = 1'b1;
        measure_busy(cnt, saw);
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL reset_busy_len: got %0d want 32", cnt);
        end
        n_vec++;
        if (saw) begin
            n_err++;
            $display("FAIL reset_rdata_during_clear: got nonzero want 0");
        end
        for (int i = 0; i < DEPTH; i++) begin
            raddr = {5'(31 - i), 5'(i)};
            #1;
            n_vec++;
            if (rdata !== '0) begin
                n_err++;
                $display("FAIL reset_entry_%0d: got %h want 0", i, rdata);
            end
        end
    endtask

    task automatic test_write_read();
        do_write(5'd5, 32'hDEADBEEF);
        do_write(5'd31, 32'h12345678);
        raddr = {5'd31, 5'd5};
        #1;
        n_vec++;
        if (rdata !== {32'h12345678, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL read_5_31: got %h want 12345678deadbeef", rdata);
        end
        raddr = {5'd5, 5'd5};
        #1;
        n_vec++;
        if (rdata !== {32'hDEADBEEF, 32'hDEADBEEF}) begin
            n_err++;
            $display("FAIL read_5_5: got %h want deadbeefdeadbeef", rdata);
        end
    endtask

    task automatic test_zero_and_busy_write();
        int cnt;
        bit saw;
        do_write(5'd0, 32'hFFFFFFFF);
        raddr = {5'd5, 5'd0};
        #1;
        n_vec++;
        if (rdata !== {32'hDEADBEEF, 32'h0}) begin
            n_err++;
            $display("FAIL zero_reg: got %h want deadbeef00000000", rdata);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        // Hold a write to entry 7 for the whole sweep
        we    = 1'b1;
        waddr = 5'd7;
        wdata = 32'h77777777;
        raddr = {5'd31, 5'd7};
        measure_busy(cnt, saw);
        we = 1'b0;
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL busy_write_len: got %0d want 32", cnt);
        end
        #1;
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL busy_write_dropped: got %h want 0", rdata);
        end
    endtask

    task automatic test_clr_retrigger();
        int cnt;
        do_write(5'd9, 32'hA5A5A5A5);
        raddr = {5'd9, 5'd9};
        #1;
        n_vec++;
        if (rdata !== {32'hA5A5A5A5, 32'hA5A5A5A5}) begin
            n_err++;
            $display("FAIL store_9: got %h want a5a5a5a5a5a5a5a5", rdata);
        end
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        cnt = 0;
        while (busy === 1'b1 && cnt < 100) begin
            clr_req = (cnt == 10);
            cnt++;
            tick();
        end
        clr_req = 1'b0;
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL retrigger_len: got %0d want 32", cnt);
        end
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL retrigger_entry_9: got %h want 0", rdata);
        end
    endtask

    task automatic test_reset_mid_clear();
        int cnt;
        bit saw;
        do_write(5'd20, 32'h55AA55AA);
        raddr = {5'd20, 5'd20};
        clr_req = 1'b1;
        tick();
        clr_req = 1'b0;
        for (int i = 0; i < 15; i++) tick();
        rst = 1'b0;
        #1;
        n_vec++;
        if (busy !== 1'b1 || rdata !== '0) begin
            n_err++;
            $display("FAIL mid_reset_state: got busy=%b rdata=%h want busy=1 rdata=0", busy, rdata);
        end
        tick();
        tick();
        rst = 1'b1;
        measure_busy(cnt, saw);
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL mid_reset_len: got %0d want 32", cnt);
        end
        n_vec++;
        if (saw) begin
            n_err++;
            $display("FAIL mid_reset_rdata: got nonzero during clear want 0");
        end
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL mid_reset_entry_20: got %h want 0", rdata);
        end
    endtask

    task automatic test_bypass();
        logic [WIDTH-1:0] exp_pre;
`ifdef REGFILE_BYPASS_EN
        exp_pre = 32'h2;
`else
        exp_pre = 32'h1;
`endif
        do_write(5'd3, 32'h1);
        do_write(5'd4, 32'h44);
        we    = 1'b1;
        waddr = 5'd3;
        wdata = 32'h2;
        raddr = {5'd4, 5'd3};
        #1;
        n_vec++;
        if (rdata !== {32'h44, exp_pre}) begin
            n_err++;
            $display("FAIL bypass_pre: got %h want %h", rdata, {32'h44, exp_pre});
        end
        tick();
        we = 1'b0;
        n_vec++;
        if (rdata !== {32'h44, 32'h2}) begin
            n_err++;
            $display("FAIL bypass_post: got %h want 0000004400000002", rdata);
        end
        // A dropped write to the zero entry must never be forwarded
        we    = 1'b1;
        waddr = 5'd0;
        wdata = 32'hCAFEF00D;
        raddr = {5'd0, 5'd0};
        #1;
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL bypass_zero: got %h want 0", rdata);
        end
        tick();
        we = 1'b0;
    endtask

    task automatic test_back_to_back();
        int cnt;
        bit saw;
        we      = 1'b1;
        waddr   = 5'd12;
        wdata   = 32'h0BADF00D;
        clr_req = 1'b1;
        raddr   = {5'd12, 5'd12};
        tick();
        we      = 1'b0;
        clr_req = 1'b0;
        measure_busy(cnt, saw);
        n_vec++;
        if (cnt != 32) begin
            n_err++;
            $display("FAIL same_edge_len: got %0d want 32", cnt);
        end
        n_vec++;
        if (rdata !== '0) begin
            n_err++;
            $display("FAIL same_edge_entry_12: got %h want 0", rdata);
        end
    endtask

    initial begin
        n_vec   = 0;
        n_err   = 0;
        rst     = 1'b1;
        clr_req = 1'b0;
        we      = 1'b0;
        waddr   = '0;
        wdata   = '0;
        raddr   = '0;
        #2;
        test_reset();
        test_write_read();
        test_zero_and_busy_write();
        test_clr_retrigger();
        test_reset_mid_clear();
        test_bypass();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
